chunked_add_sub: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock through a registered carry chain, trading latency for a narrow adder. It is the sequenced successor of the team's fixed-width ripple adders. Results sit in a datapath next to register files and ALU control: start/busy/done handshake in, held result out.

---
 rtl/chunked_add_sub.sv | 131 +++++++++++++
 tb/tb_chunked_add_sub.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: a WIDTH-bit operand pair is summed CHUNK bits per
// clock through a registered carry, with a start/busy/done handshake and held result.
module chunked_add_sub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] a_ch [NCHUNK];
   logic [CHUNK-1:0] b_ch [NCHUNK];
   logic [CHUNK-1:0] a_cur, b_cur, sum_cur;
   logic             carry_out, carry_msb_in;

   generate
      for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
         assign a_ch[gi] = a_q[gi*CHUNK +: CHUNK];
         assign b_ch[gi] = b_q[gi*CHUNK +: CHUNK];
      end
   endgenerate

   // Narrow chunk adder; carry into the top bit is recovered from the sum bit.
   always_comb begin
      a_cur = a_ch[idx_q];
      b_cur = b_ch[idx_q];
      {carry_out, sum_cur} = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_q};
      carry_msb_in = a_cur[CHUNK-1] ^ b_cur[CHUNK-1] ^ sum_cur[CHUNK-1];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               // Subtraction is folded into addition: a + ~b + 1.
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               s_d     = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (idx_q == IW'(i)) begin
                  s_d[i*CHUNK +: CHUNK] = sum_cur;
               end
            end
            carry_d = carry_out;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = carry_out;
               ovf_d   = carry_msb_in ^ carry_out;
               idx_d   = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: directed vectors and handshake sequences on the 16/4
// instance, then random add/sub ops on 16/4, 8/8 and 12/3 instances against a model.
module tb_chunked_add_sub;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a_in, b_in;
   logic        cin_in, sub_in;

   logic        busy16, done16, cout16, ovf16;
   logic [15:0] s16;
   logic        busy8, done8, cout8, ovf8;
   logic [7:0]  s8;
   logic        busy12, done12, cout12, ovf12;
   logic [11:0] s12;

   logic [2:0]  busy_w, done_w, cout_w, ovf_w;
   logic [15:0] s_w [3];

   localparam int WD [3] = '{16, 8, 12};
   localparam int NC [3] = '{4, 1, 4};

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
      .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16));

   chunked_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in), .sub(sub_in),
      .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8));

   chunked_add_sub #(.WIDTH(12), .CHUNK(3)) dut12 (
      .clk(clk), .rst(rst), .start(start), .a(a_in[11:0]), .b(b_in[11:0]), .cin(cin_in), .sub(sub_in),
      .busy(busy12), .done(done12), .s(s12), .cout(cout12), .ovf(ovf12));

   assign busy_w = {busy12, busy8, busy16};
   assign done_w = {done12, done8, done16};
   assign cout_w = {cout12, cout8, cout16};
   assign ovf_w  = {ovf12, ovf8, ovf16};
   assign s_w[0] = s16;
   assign s_w[1] = {8'h00, s8};
   assign s_w[2] = {4'h0, s12};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Reference: plain unsigned/signed integer arithmetic at width w.
   function automatic logic [17:0] model(input int w, input logic [15:0] ta, input logic [15:0] tb,
                                         input logic tcin, input logic tsub);
      longint mask, ua, ub, sa, sb, full, sres, lim;
      logic   c, o;
      mask = (longint'(1) << w) - 1;
      lim  = longint'(1) << (w - 1);
      ua   = longint'(ta) & mask;
      ub   = longint'(tb) & mask;
      sa   = (ua >= lim) ? ua - (longint'(1) << w) : ua;
      sb   = (ub >= lim) ? ub - (longint'(1) << w) : ub;
      if (tsub) begin
         full = ua - ub;
         c    = (ua >= ub);
         sres = sa - sb;
      end else begin
         full = ua + ub + longint'(tcin);
         c    = (full > mask);
         sres = sa + sb + longint'(tcin);
      end
      o = (sres >= lim) || (sres < -lim);
      return {o, c, 16'(full & mask)};
   endfunction

   // Starts one op from IDLE/DONE (called at a negedge), watches 8 cycles, checks latency
   // on each instance and, with chk_all, results against the model.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                         input logic tsub, input bit chk_all, input string tag,
                         output logic [15:0] rs, output logic rc, output logic ro);
      int          dcyc [3];
      int          bcnt [3];
      logic [15:0] cs [3];
      logic        cc [3];
      logic        co [3];
      logic [17:0] m;
      for (int k = 0; k < 3; k++) begin
         dcyc[k] = 0; bcnt[k] = 0; cs[k] = '0; cc[k] = 1'b0; co[k] = 1'b0;
      end
      a_in = ta; b_in = tb; cin_in = tcin; sub_in = tsub; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         for (int k = 0; k < 3; k++) begin
            if (busy_w[k]) bcnt[k]++;
            if (done_w[k] && dcyc[k] == 0) begin
               dcyc[k] = j;
               cs[k] = s_w[k]; cc[k] = cout_w[k]; co[k] = ovf_w[k];
            end
         end
         if (j < 8) @(negedge clk);
      end
      for (int k = 0; k < 3; k++) begin
         if (chk_all || k == 0) begin
            check($sformatf("%s w%0d done_cycle", tag, WD[k]), dcyc[k], NC[k] + 1);
            check($sformatf("%s w%0d busy_cycles", tag, WD[k]), bcnt[k], NC[k]);
         end
         if (chk_all) begin
            m = model(WD[k], ta, tb, tcin, tsub);
            check($sformatf("%s w%0d s", tag, WD[k]), {16'h0, cs[k]}, {16'h0, m[15:0]});
            check($sformatf("%s w%0d cout", tag, WD[k]), {31'h0, cc[k]}, {31'h0, m[16]});
            check($sformatf("%s w%0d ovf", tag, WD[k]), {31'h0, co[k]}, {31'h0, m[17]});
            check($sformatf("%s w%0d s_held", tag, WD[k]), {16'h0, s_w[k]}, {16'h0, m[15:0]});
         end
      end
      rs = cs[0]; rc = cc[0]; ro = co[0];
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t        vecs [8];
   logic [15:0] rs;
   logic        rc, ro;
   int          dn, dcy;

   initial begin
      vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

      rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset busy", {31'h0, busy16}, 0);
      check("reset done", {31'h0, done16}, 0);
      check("reset s", {16'h0, s16}, 0);
      check("reset cout_ovf", {30'h0, cout16, ovf16}, 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0, $sformatf("vec%0d", i), rs, rc, ro);
         check($sformatf("vec%0d s", i), {16'h0, rs}, {16'h0, vecs[i].s});
         check($sformatf("vec%0d cout", i), {31'h0, rc}, {31'h0, vecs[i].cout});
         check($sformatf("vec%0d ovf", i), {31'h0, ro}, {31'h0, vecs[i].ovf});
         check($sformatf("vec%0d s_held", i), {16'h0, s16}, {16'h0, vecs[i].s});
         check($sformatf("vec%0d flags_held", i), {30'h0, cout16, ovf16}, {30'h0, vecs[i].cout, vecs[i].ovf});
      end

      // start and new operands during RUN are ignored
      a_in = 16'h1234; b_in = 16'h1111; cin_in = 1'b0; sub_in = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_in = 16'hFFFF; b_in = 16'hFFFF; sub_in = 1'b1;
      dcy = 0; rs = '0;
      for (int j = 1; j <= 8; j++) begin
         if (j == 2) start = 1'b0;
         if (done16 && dcy == 0) begin dcy = j; rs = s16; end
         if (j < 8) @(negedge clk);
      end
      check("run_ignore done_cycle", dcy, 5);
      check("run_ignore s", {16'h0, rs}, 32'h2345);

      // start held through DONE: back-to-back accept
      a_in = 16'h0001; b_in = 16'h0002; cin_in = 1'b0; sub_in = 1'b0; start = 1'b1;
      @(posedge clk);
      repeat (5) @(negedge clk);
      check("b2b first done", {31'h0, done16}, 1);
      check("b2b first s", {16'h0, s16}, 32'h0003);
      a_in = 16'h0010; b_in = 16'h0020; cin_in = 1'b1;
      @(negedge clk);
      check("b2b second busy", {31'h0, busy16}, 1);
      check("b2b second done_low", {31'h0, done16}, 0);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("b2b second done", {31'h0, done16}, 1);
      check("b2b second s", {16'h0, s16}, 32'h0031);
      @(negedge clk);

      // reset in the second RUN cycle discards the op
      a_in = 16'h1234; b_in = 16'h1111; cin_in = 1'b0; sub_in = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst busy", {31'h0, busy16}, 0);
      check("midrst done", {31'h0, done16}, 0);
      check("midrst s", {16'h0, s16}, 0);
      check("midrst cout_ovf", {30'h0, cout16, ovf16}, 0);
      rst = 1'b0;
      dn = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (done16) dn++;
      end
      check("midrst no_done", dn, 0);
      run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "post_rst", rs, rc, ro);
      check("post_rst s", {16'h0, rs}, 32'h0100);

      // random sweep on all three instances
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h8000;
         if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'h7FFF;
         run_op(ra, rb, 1'($urandom), 1'($urandom), 1'b1, $sformatf("rnd%0d", i), rs, rc, ro);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
